// File: rtl/frodo_host_seq_if.sv
// Stream-side bundle of the FrodoKEM host sequencer: job descriptor,
// host source/sink streams and the cmd/in/out channels of `main`.
interface frodo_host_seq_if #(
    parameter int CMD_SIZE = 8,
    parameter int CNT_W    = 16
);
    // job descriptor
    logic [CMD_SIZE-1:0] job_cmd;
    logic [CNT_W-1:0]    job_sendWords;
    logic [CNT_W-1:0]    job_recvWords;
    logic                job_swap;
    logic                job_isReady;
    logic                job_canReceive;
    // host source stream
    logic [63:0]         src_data;
    logic                src_isReady;
    logic                src_canReceive;
    // `main` command channel
    logic [CMD_SIZE-1:0] dut_cmd;
    logic                dut_cmd_isReady;
    logic                dut_cmd_canReceive;
    // `main` input channel
    logic [63:0]         dut_in;
    logic                dut_in_isReady;
    logic                dut_in_canReceive;
    // `main` output channel
    logic [63:0]         dut_out;
    logic                dut_out_isReady;
    logic                dut_out_canReceive;
    // host sink stream
    logic [63:0]         snk_data;
    logic                snk_isReady;
    logic                snk_canReceive;
    // status
    logic                busy;
    logic                done;

    // sequencer side
    modport master (
        input  job_cmd, job_sendWords, job_recvWords, job_swap, job_isReady,
        output job_canReceive,
        input  src_data, src_isReady,
        output src_canReceive,
        output dut_cmd, dut_cmd_isReady,
        input  dut_cmd_canReceive,
        output dut_in, dut_in_isReady,
        input  dut_in_canReceive,
        input  dut_out, dut_out_isReady,
        output dut_out_canReceive,
        output snk_data, snk_isReady,
        input  snk_canReceive,
        output busy, done
    );

    // environment side (host DMA/FIFO plus `main`)
    modport slave (
        output job_cmd, job_sendWords, job_recvWords, job_swap, job_isReady,
        input  job_canReceive,
        output src_data, src_isReady,
        input  src_canReceive,
        input  dut_cmd, dut_cmd_isReady,
        output dut_cmd_canReceive,
        input  dut_in, dut_in_isReady,
        output dut_in_canReceive,
        output dut_out, dut_out_isReady,
        input  dut_out_canReceive,
        input  snk_data, snk_isReady,
        output snk_canReceive,
        input  busy, done
    );
endinterface

// File: rtl/frodo_host_seq.sv
// Host-side initiator for the FrodoKEM `main` core: accepts a job, issues
// its command, then streams words in and out concurrently with optional
// 64-bit byte reversal. Both data paths are zero-latency pass-through.
module frodo_host_seq #(
    parameter int CMD_SIZE = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    frodo_host_seq_if.master  bus
);

    typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    send_left_q, send_left_d;
    logic [CNT_W-1:0]    recv_left_q, recv_left_d;
    logic [CMD_SIZE-1:0] cmd_q, cmd_d;
    logic                swap_q, swap_d;

    logic                job_can_o;
    logic                src_can_o;
    logic [CMD_SIZE-1:0] cmd_o;
    logic                cmd_rdy_o;
    logic [63:0]         in_o;
    logic                in_rdy_o;
    logic                out_can_o;
    logic [63:0]         snk_o;
    logic                snk_rdy_o;
    logic                busy_o;
    logic                done_o;

    logic                send_act;
    logic                recv_act;

    // byte k of the word moves to byte 7-k
    function automatic logic [63:0] byteswap(input logic [63:0] w);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = w[8*(7-k) +: 8];
        return r;
    endfunction

    assign send_act = (send_left_q != '0);
    assign recv_act = (recv_left_q != '0);

    // next state, counters and all channel outputs; rst forces outputs low
    always_comb begin
        state_d     = state_q;
        send_left_d = send_left_q;
        recv_left_d = recv_left_q;
        cmd_d       = cmd_q;
        swap_d      = swap_q;
        job_can_o   = 1'b0;
        src_can_o   = 1'b0;
        cmd_o       = '0;
        cmd_rdy_o   = 1'b0;
        in_o        = '0;
        in_rdy_o    = 1'b0;
        out_can_o   = 1'b0;
        snk_o       = '0;
        snk_rdy_o   = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                job_can_o = 1'b1;
                if (bus.job_isReady) begin
                    cmd_d       = bus.job_cmd;
                    send_left_d = bus.job_sendWords;
                    recv_left_d = bus.job_recvWords;
                    swap_d      = bus.job_swap;
                    state_d     = CMD;
                end
            end
            CMD: begin
                cmd_o     = cmd_q;
                cmd_rdy_o = 1'b1;
                if (bus.dut_cmd_canReceive) state_d = XFER;
            end
            XFER: begin
                // send path: source -> `main` in
                in_rdy_o  = send_act & bus.src_isReady;
                src_can_o = send_act & bus.dut_in_canReceive;
                if (in_rdy_o)
                    in_o = swap_q ? byteswap(bus.src_data) : bus.src_data;
                if (in_rdy_o && bus.dut_in_canReceive)
                    send_left_d = send_left_q - 1'b1;
                // receive path: `main` out -> sink
                snk_rdy_o = recv_act & bus.dut_out_isReady;
                out_can_o = recv_act & bus.snk_canReceive;
                if (snk_rdy_o)
                    snk_o = swap_q ? byteswap(bus.dut_out) : bus.dut_out;
                if (snk_rdy_o && bus.snk_canReceive)
                    recv_left_d = recv_left_q - 1'b1;
                // leave on the same edge as the final transfer
                if (send_left_d == '0 && recv_left_d == '0) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            job_can_o = 1'b0;
            src_can_o = 1'b0;
            cmd_o     = '0;
            cmd_rdy_o = 1'b0;
            in_o      = '0;
            in_rdy_o  = 1'b0;
            out_can_o = 1'b0;
            snk_o     = '0;
            snk_rdy_o = 1'b0;
            busy_o    = 1'b0;
            done_o    = 1'b0;
        end
    end

    // state and job registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            send_left_q <= '0;
            recv_left_q <= '0;
            cmd_q       <= '0;
            swap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            send_left_q <= send_left_d;
            recv_left_q <= recv_left_d;
            cmd_q       <= cmd_d;
            swap_q      <= swap_d;
        end
    end

    assign bus.job_canReceive     = job_can_o;
    assign bus.src_canReceive     = src_can_o;
    assign bus.dut_cmd            = cmd_o;
    assign bus.dut_cmd_isReady    = cmd_rdy_o;
    assign bus.dut_in             = in_o;
    assign bus.dut_in_isReady     = in_rdy_o;
    assign bus.dut_out_canReceive = out_can_o;
    assign bus.snk_data           = snk_o;
    assign bus.snk_isReady        = snk_rdy_o;
    assign bus.busy               = busy_o;
    assign bus.done               = done_o;

endmodule

// File: tb/tb_frodo_host_seq.sv
// Directed bench for frodo_host_seq: inputs change 1ns after posedge,
// outputs are sampled at the following negedge.
module tb_frodo_host_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    frodo_host_seq_if #(.CMD_SIZE(8), .CNT_W(16)) bus();

    frodo_host_seq #(.CMD_SIZE(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    task automatic idle_inputs();
        bus.job_cmd            = '0;
        bus.job_sendWords      = '0;
        bus.job_recvWords      = '0;
        bus.job_swap           = 1'b0;
        bus.job_isReady        = 1'b0;
        bus.src_data           = '0;
        bus.src_isReady        = 1'b0;
        bus.dut_cmd_canReceive = 1'b0;
        bus.dut_in_canReceive  = 1'b0;
        bus.dut_out            = '0;
        bus.dut_out_isReady    = 1'b0;
        bus.snk_canReceive     = 1'b0;
    endtask

    // hands a job over in IDLE and completes the command handshake;
    // returns 1ns into the first XFER cycle
    task automatic issue_job(input logic [7:0] cmd, input logic [15:0] s,
                             input logic [15:0] r, input logic sw);
        bus.job_cmd       = cmd;
        bus.job_sendWords = s;
        bus.job_recvWords = r;
        bus.job_swap      = sw;
        bus.job_isReady   = 1'b1;
        tick();
        bus.job_isReady        = 1'b0;
        bus.dut_cmd_canReceive = 1'b1;
        tick();
        bus.dut_cmd_canReceive = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] dn = 2'b00;
        rst = 1'b1;
        idle_inputs();
        bus.src_isReady     = 1'b1;
        bus.dut_out_isReady = 1'b1;
        bus.job_isReady     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            n_tests++;
            if ({bus.job_canReceive, bus.src_canReceive, bus.dut_cmd, bus.dut_cmd_isReady,
                 bus.dut_in, bus.dut_in_isReady, bus.dut_out_canReceive, bus.snk_data,
                 bus.snk_isReady, bus.busy, bus.done} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got nonzero output, want all 0", c);
            end
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        sample();
        n_tests++;
        if (bus.job_canReceive !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: job_canReceive got %b want 1", bus.job_canReceive);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            if (bus.done !== 1'b0) dn = 2'b01;
        end
        n_tests++;
        if (dn !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_no_done: done pulsed got 1 want 0");
        end
    endtask

    task automatic test_swap_job();
        logic [63:0] w0 = 64'h0011223344556677;
        logic [63:0] w1 = 64'h8899AABBCCDDEEFF;
        int cmd_cycles = 0;
        tick();
        bus.job_cmd       = 8'h05;
        bus.job_sendWords = 16'd2;
        bus.job_recvWords = 16'd0;
        bus.job_swap      = 1'b1;
        bus.job_isReady   = 1'b1;
        tick();
        bus.job_isReady        = 1'b0;
        bus.dut_cmd_canReceive = 1'b1;
        bus.dut_in_canReceive  = 1'b1;
        bus.src_isReady        = 1'b1;
        bus.src_data           = w0;
        // cycle 0: CMD
        sample();
        if (bus.dut_cmd_isReady === 1'b1 && bus.dut_cmd === 8'h05) cmd_cycles++;
        n_tests++;
        if (bus.dut_cmd !== 8'h05 || bus.dut_cmd_isReady !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_cmd: got %h/%b want 05/1", bus.dut_cmd, bus.dut_cmd_isReady);
        end
        // cycle 1: XFER word 0
        tick();
        sample();
        if (bus.dut_cmd_isReady === 1'b1) cmd_cycles++;
        n_tests++;
        if (bus.dut_in !== 64'h7766554433221100 || bus.dut_in_isReady !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_word0: got %h/%b want 7766554433221100/1", bus.dut_in, bus.dut_in_isReady);
        end
        n_tests++;
        if (bus.dut_cmd !== 8'h00) begin
            n_fail++;
            $display("FAIL swap_cmd_clear: dut_cmd got %h want 00", bus.dut_cmd);
        end
        // cycle 2: XFER word 1
        tick();
        bus.src_data = w1;
        sample();
        if (bus.dut_cmd_isReady === 1'b1) cmd_cycles++;
        n_tests++;
        if (bus.dut_in !== 64'hFFEEDDCCBBAA9988 || bus.src_canReceive !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_word1: got %h/%b want FFEEDDCCBBAA9988/1", bus.dut_in, bus.src_canReceive);
        end
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_early_done: got 1 want 0");
        end
        // cycle 3: DONE, source still offering but must not be taken
        tick();
        sample();
        n_tests++;
        if (bus.done !== 1'b1 || bus.dut_in_isReady !== 1'b0 || bus.src_canReceive !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_done: done/in_rdy/src_can got %b%b%b want 100",
                     bus.done, bus.dut_in_isReady, bus.src_canReceive);
        end
        n_tests++;
        if (cmd_cycles !== 1) begin
            n_fail++;
            $display("FAIL swap_cmd_once: cmd cycles got %0d want 1", cmd_cycles);
        end
        tick();
        sample();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.job_canReceive !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_back_idle: done/busy/job_can got %b%b%b want 001",
                     bus.done, bus.busy, bus.job_canReceive);
        end
        idle_inputs();
    endtask

    task automatic test_concurrent();
        logic [63:0] s_w [3] = '{64'hA000_0000_0000_0001, 64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003};
        logic [63:0] o_w [4] = '{64'h0102030405060708, 64'h1112131415161718,
                                 64'h2122232425262728, 64'h3132333435363738};
        int sc = 0, rc = 0, bad_data = 0, bad_can = 0, last_x = -1, done_c = -1;
        logic tog = 1'b1;
        tick();
        issue_job(8'h21, 16'd3, 16'd4, 1'b0);
        bus.dut_in_canReceive = 1'b1;
        bus.src_isReady       = 1'b1;
        bus.dut_out_isReady   = 1'b1;
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            if (c != 0) tick();
            bus.src_data       = s_w[sc < 3 ? sc : 2];
            bus.dut_out        = o_w[rc < 4 ? rc : 3];
            bus.snk_canReceive = tog;
            tog = ~tog;
            sample();
            if (bus.snk_canReceive === 1'b0 && bus.dut_out_canReceive === 1'b1) bad_can++;
            if (bus.done === 1'b1) done_c = c;
            if (bus.dut_in_isReady === 1'b1 && bus.dut_in_canReceive === 1'b1) begin
                if (sc >= 3 || bus.dut_in !== s_w[sc]) bad_data++;
                sc++;
                last_x = c;
            end
            if (bus.snk_isReady === 1'b1 && bus.snk_canReceive === 1'b1) begin
                if (rc >= 4 || bus.snk_data !== o_w[rc]) bad_data++;
                rc++;
                last_x = c;
            end
        end
        n_tests++;
        if (sc !== 3 || rc !== 4) begin
            n_fail++;
            $display("FAIL conc_counts: sent/recv got %0d/%0d want 3/4", sc, rc);
        end
        n_tests++;
        if (bad_data !== 0) begin
            n_fail++;
            $display("FAIL conc_data: bad words got %0d want 0", bad_data);
        end
        n_tests++;
        if (bad_can !== 0) begin
            n_fail++;
            $display("FAIL conc_out_can: out_canReceive without snk_canReceive got %0d want 0", bad_can);
        end
        n_tests++;
        if (done_c < 0 || done_c !== last_x + 1) begin
            n_fail++;
            $display("FAIL conc_done: done cycle got %0d want %0d", done_c, last_x + 1);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_zero_job();
        tick();
        issue_job(8'h33, 16'd0, 16'd0, 1'b0);
        bus.src_isReady       = 1'b1;
        bus.dut_in_canReceive = 1'b1;
        bus.dut_out_isReady   = 1'b1;
        bus.snk_canReceive    = 1'b1;
        sample();
        n_tests++;
        if ({bus.dut_in_isReady, bus.src_canReceive, bus.snk_isReady, bus.dut_out_canReceive,
             bus.done, bus.busy} !== 6'b000001) begin
            n_fail++;
            $display("FAIL zero_xfer: in/src/snk/out/done/busy got %b%b%b%b%b%b want 000001",
                     bus.dut_in_isReady, bus.src_canReceive, bus.snk_isReady,
                     bus.dut_out_canReceive, bus.done, bus.busy);
        end
        tick();
        sample();
        n_tests++;
        if (bus.done !== 1'b1 || bus.dut_in_isReady !== 1'b0 || bus.dut_out_canReceive !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done got %b want 1", bus.done);
        end
        tick();
        sample();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: done/busy got %b%b want 00", bus.done, bus.busy);
        end
        idle_inputs();
    endtask

    task automatic test_overrun();
        int fwd = 0;
        logic late = 1'b0;
        tick();
        issue_job(8'h44, 16'd0, 16'd1, 1'b0);
        bus.dut_out_isReady = 1'b1;
        bus.dut_out         = 64'hDEAD_BEEF_0000_0001;
        bus.snk_canReceive  = 1'b1;
        sample();
        if (bus.snk_isReady === 1'b1 && bus.dut_out_canReceive === 1'b1) fwd++;
        n_tests++;
        if (bus.snk_data !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL over_word: got %h want deadbeef00000001", bus.snk_data);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.dut_out = 64'hDEAD_BEEF_0000_0002 + 64'(c);
            sample();
            if (bus.snk_isReady === 1'b1 && bus.dut_out_canReceive === 1'b1) fwd++;
            if (bus.dut_out_canReceive !== 1'b0 || bus.snk_data !== '0) late = 1'b1;
        end
        n_tests++;
        if (fwd !== 1) begin
            n_fail++;
            $display("FAIL over_count: forwarded got %0d want 1", fwd);
        end
        n_tests++;
        if (late !== 1'b0) begin
            n_fail++;
            $display("FAIL over_guard: out_canReceive/snk_data after last got active want 0");
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_job();
        int got_done = 0, sc = 0;
        logic bad = 1'b0;
        tick();
        issue_job(8'h55, 16'd10, 16'd0, 1'b0);
        bus.src_isReady       = 1'b1;
        bus.dut_in_canReceive = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.src_data = 64'(c);
            sample();
            if (bus.done === 1'b1) got_done++;
            tick();
        end
        rst = 1'b1;
        sample();
        n_tests++;
        if (bus.dut_in_isReady !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: in_rdy/done got %b%b want 00", bus.dut_in_isReady, bus.done);
        end
        tick();
        rst = 1'b0;
        sample();
        if (bus.done === 1'b1) got_done++;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.dut_in_isReady !== 1'b0 || got_done !== 0) begin
            n_fail++;
            $display("FAIL midrst_after: busy/in_rdy/dones got %b/%b/%0d want 0/0/0",
                     bus.busy, bus.dut_in_isReady, got_done);
        end
        // fresh job must restart from word 0
        tick();
        issue_job(8'h56, 16'd2, 16'd0, 1'b0);
        bus.src_isReady       = 1'b1;
        bus.dut_in_canReceive = 1'b1;
        for (int c = 0; c < 10 && got_done == 0; c++) begin
            if (c != 0) tick();
            bus.src_data = 64'hF000 + 64'(sc);
            sample();
            if (bus.done === 1'b1) got_done++;
            if (bus.dut_in_isReady === 1'b1 && bus.dut_in_canReceive === 1'b1) begin
                if (bus.dut_in !== 64'hF000 + 64'(sc)) bad = 1'b1;
                sc++;
            end
        end
        n_tests++;
        if (sc !== 2 || got_done !== 1 || bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_fresh: words/done/bad got %0d/%0d/%b want 2/1/0", sc, got_done, bad);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_swap_job();
        test_concurrent();
        test_zero_job();
        test_overrun();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frodo_host_seq.md
Name: frodo_host_seq

Overview:
- Host-side initiator for the `main` FrodoKEM core's command/in/out stream interface.
- Accepts one job descriptor, issues the command word to `main`, then streams a fixed number of 64-bit words from a source stream into `main`. In parallel it drains a fixed number of 64-bit words from `main` into a sink stream.
- Optional per-job 64-bit byte reversal on both data directions.
- Replaces hand-written bench sequencing; sits between a host DMA/FIFO and `main`.

Parameters:
- CMD_SIZE, 8, width of the command word; instantiated with `MainCMD_SIZE`.
- CNT_W, 16, width of the word counters. Largest job is decaps input, about 5.4k words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- job_cmd  in  CMD_SIZE  command to issue
- job_sendWords  in  CNT_W  number of 64-bit words to push into `main`
- job_recvWords  in  CNT_W  number of 64-bit words to pull from `main`
- job_swap  in  1  1 = byte-reverse each 64-bit word in both directions
- job_isReady  in  1  job descriptor valid
- job_canReceive  out  1  sequencer idle, accepts a job
- src_data  in  64  host words toward `main`
- src_isReady  in  1  src_data valid
- src_canReceive  out  1  word consumed this cycle
- dut_cmd  out  CMD_SIZE  to `main` cmd
- dut_cmd_isReady  out  1  to `main` cmd_isReady
- dut_cmd_canReceive  in  1  from `main` cmd_canReceive
- dut_in  out  64  to `main` in
- dut_in_isReady  out  1  to `main` in_isReady
- dut_in_canReceive  in  1  from `main` in_canReceive
- dut_out  in  64  from `main` out
- dut_out_isReady  in  1  from `main` out_isReady
- dut_out_canReceive  out  1  to `main` out_canReceive
- snk_data  out  64  words from `main` toward host
- snk_isReady  out  1  snk_data valid
- snk_canReceive  in  1  host accepts
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Handshake rule on every channel: a transfer occurs on a rising clk edge where isReady and canReceive are both 1. isReady must never depend combinationally on canReceive of the same channel.
- Reset: synchronous, takes effect on a clk edge with rst=1.
  - State becomes IDLE; sendLeft, recvLeft, cmdReg and swapReg are cleared.
  - All outputs are 0 while rst=1; data outputs are 0 whenever not valid.
  - job_canReceive stays 0 while rst=1 and rises in the first cycle after rst falls.
- FSM states IDLE, CMD, XFER, DONE.
  - IDLE: job_canReceive=1. On a job transfer, latch cmdReg, sendLeft, recvLeft and swapReg, then go to CMD.
  - CMD: dut_cmd=cmdReg, dut_cmd_isReady=1. On a command transfer go to XFER; cmd outputs are 0 from the next cycle.
  - XFER, send path (zero-latency pass-through):
    - sendAct = (sendLeft != 0).
    - dut_in = swapReg ? byteswap(src_data) : src_data, where byte k maps to byte 7-k.
    - dut_in_isReady = sendAct & src_isReady.
    - src_canReceive = sendAct & dut_in_canReceive.
    - sendLeft decrements on each transfer.
  - XFER, receive path (zero-latency pass-through):
    - recvAct = (recvLeft != 0).
    - snk_data = swapReg ? byteswap(dut_out) : dut_out.
    - snk_isReady = recvAct & dut_out_isReady.
    - dut_out_canReceive = recvAct & snk_canReceive.
    - recvLeft decrements on each transfer.
  - The send and receive paths run concurrently and independently. Output may begin before all input is sent; this is mandatory to avoid deadlock with streaming `main` operations.
  - XFER exit: when sendLeft==0 and recvLeft==0 at a clock edge, go to DONE. This includes the cycle in which the final words transfer, so the last decrement and the exit happen on the same edge.
  - A job with both counts 0 spends exactly one cycle in XFER.
  - DONE: done=1 for exactly one cycle, then IDLE. job_canReceive=0 in DONE.
- Once a counter reaches 0, its channel's isReady and canReceive are forced to 0. Extra `main` output words are never consumed; extra source words are never taken.
- New jobs are ignored while busy, because job_canReceive=0.
- Reset mid-job abandons the job with no done pulse. Words already transferred are not replayed.
- Total cycles for a job with no stalls: 1 (IDLE accept) + 1 (CMD) + max(S,R,1) (XFER) + 1 (DONE), where S = sendWords and R = recvWords.

Test Plan:
- Reset then idle: rst high for 3 cycles -> all outputs 0; job_canReceive=1 on the cycle after rst falls; done never pulses.
- Job cmd=8'h05, send=2, recv=0, swap=1; src words 64'h0011223344556677, 64'h8899AABBCCDDEEFF; `main` always ready:
  - dut_cmd=8'h05 for exactly one cycle.
  - dut_in sees 64'h7766554433221100 then 64'hFFEEDDCCBBAA9988.
  - done pulses 3 cycles after the cmd transfer.
- Concurrent job send=3, recv=4, swap=0; dut_out provides 4 words starting while send is still active; snk_canReceive toggles every other cycle:
  - snk receives the 4 words unmodified and in order.
  - dut_out_canReceive is never 1 while snk_canReceive=0.
  - done pulses after the last of the 7 transfers.
- Zero job send=0, recv=0 -> cmd issued; XFER lasts 1 cycle; done pulses; no in/out handshake asserted.
- Overrun guard: recv=1 while `main` holds out_isReady=1 for 3 words -> exactly 1 word forwarded; dut_out_canReceive=0 afterwards.
- Reset mid-job: assert rst after 5 of 10 send words -> on the next edge busy=0 and dut_in_isReady=0, with no done pulse. A fresh job then completes normally from word 0.
